// File: rtl/sc_stoch_to_bin.sv
// sc_stoch_to_bin: stochastic-to-binary converter.
// Counts the ones in a window of 2**WIN_LOG2 qualified bitstream cycles. The
// binary estimate is then offered on a valid/ready output port.
// Build option: define SC_S2B_BIPOLAR_EN for the bipolar (two's-complement)
// readout 2*ones - N, saturated to N-1 at the top. When it is undefined the
// readout is unipolar: out_data = ones.
module sc_stoch_to_bin #(
    parameter int WIN_LOG2 = 8
) (
    input  logic              clk,
    input  logic              reset,      // synchronous, active-low
    input  logic              start,
    input  logic              x,
    input  logic              x_en,
    output logic              busy,
    output logic [WIN_LOG2:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WIN_LOG2:0]   ones_q, ones_d;
    logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
    logic [WIN_LOG2:0]   out_data_q, out_data_d;

    logic                launch;    // a new window begins on this edge
    logic                last_bit;  // the N-th qualified bit is being sampled
    logic [WIN_LOG2:0]   ones_sum;  // running count including the current bit
    logic [WIN_LOG2:0]   result;    // converted value of ones_sum

    // A start is honoured from IDLE, or from HOLD in the same cycle the result is accepted.
    assign launch   = start && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
    assign last_bit = x_en && (&win_cnt_q);
    assign ones_sum = ones_q + {{WIN_LOG2{1'b0}}, x};

`ifdef SC_S2B_BIPOLAR_EN
    // Bipolar readout: 2*ones - N. Only ones == N overflows the signed range, so it saturates to N-1.
    localparam logic [WIN_LOG2:0] HALF_SCALE = {1'b1, {WIN_LOG2{1'b0}}};
    localparam logic [WIN_LOG2:0] POS_SAT    = {1'b0, {WIN_LOG2{1'b1}}};

    // Convert the final count into the two's-complement estimate.
    always_comb begin
        if (ones_sum[WIN_LOG2]) begin
            result = POS_SAT;
        end else begin
            result = {ones_sum[WIN_LOG2-1:0], 1'b0} - HALF_SCALE;
        end
    end
`else
    // Unipolar readout: the count itself, 0..N.
    assign result = ones_sum;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. start during ACCUM is deliberately ignored.
    always_comb begin
        // NOTE: a default assignment first keeps every path assigned, so no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (last_bit) state_d = HOLD;
            HOLD:    if (out_ready) state_d = start ? ACCUM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode. Both flags come straight from the registered state.
    always_comb begin
        busy      = (state_q == ACCUM);
        out_valid = (state_q == HOLD);
    end

    // Datapath next-state: clear on launch, accumulate qualified bits, capture the result on the last bit.
    always_comb begin
        ones_d     = ones_q;
        win_cnt_d  = win_cnt_q;
        out_data_d = out_data_q;
        if (launch) begin
            ones_d    = '0;
            win_cnt_d = '0;
        end else if ((state_q == ACCUM) && x_en) begin
            ones_d    = ones_sum;
            win_cnt_d = win_cnt_q + 1'b1;
            if (last_bit) begin
                out_data_d = result;
            end
        end
    end

    // Datapath registers. Reset clears everything, discarding any window in flight.
    always_ff @(posedge clk) begin
        // NOTE: these are plain registers rather than a memory, so resetting them costs nothing and keeps readout deterministic.
        if (!reset) begin
            ones_q     <= '0;
            win_cnt_q  <= '0;
            out_data_q <= '0;
        end else begin
            ones_q     <= ones_d;
            win_cnt_q  <= win_cnt_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_data = out_data_q;

endmodule

// File: tb/tb_sc_stoch_to_bin.sv
// Self-checking bench for sc_stoch_to_bin with WIN_LOG2=4 (N=16).
// Expected results come from counting the ones of each stimulus window and applying the
// unipolar or bipolar readout rule. The expected completion cycle comes from the
// window length plus the number of stall cycles.
module tb_sc_stoch_to_bin;

    localparam int W = 4;
    localparam int N = 1 << W;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         x;
    logic         x_en;
    logic         busy;
    logic [W:0]   out_data;
    logic         out_valid;
    logic         out_ready;

    int total = 0;
    int bad   = 0;

    sc_stoch_to_bin #(.WIN_LOG2(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .x         (x),
        .x_en      (x_en),
        .busy      (busy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference readout of one complete window of bits.
    function automatic logic [W:0] expect_of(input logic [N-1:0] bits);
        int ones;
        int v;
        ones = $countones(bits);
`ifdef SC_S2B_BIPOLAR_EN
        v = (ones == N) ? N - 1 : 2 * ones - N;
`else
        v = ones;
`endif
        return v[W:0];
    endfunction

    // Feed one window with bits[0] first and n_stall x_en=0 cycles scattered in it.
    // The task then checks the timing and value of the result.
    // do_start=0 means the window was already launched by the caller.
    // poke_start pulses start inside the window; that start must be ignored.
    task automatic run_window(input string tag, input logic [N-1:0] bits, input int n_stall,
                              input bit do_start, input bit poke_start);
        int stall_before[N];
        int cycles;
        for (int i = 0; i < N; i++) stall_before[i] = 0;
        for (int s = 0; s < n_stall; s++) stall_before[$urandom_range(0, N-1)]++;
        cycles = 0;
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            cycles++;
            check({tag, "_busy"}, 32'(busy), 32'd1);
        end
        for (int i = 0; i < N; i++) begin
            for (int s = 0; s < stall_before[i]; s++) begin
                x_en  = 1'b0;
                x     = 1'b1;
                start = poke_start;
                tick();
                start = 1'b0;
                cycles++;
            end
            if (i == N - 1) check({tag, "_early"}, 32'(out_valid), 32'd0);
            x_en = 1'b1;
            x    = bits[i];
            if (poke_start && i == 8) start = 1'b1;
            tick();
            start = 1'b0;
            x_en  = 1'b0;
            x     = 1'b0;
            cycles++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(expect_of(bits)));
        check({tag, "_lat"}, 32'(cycles), 32'(N + n_stall + (do_start ? 1 : 0)));
    endtask

    task automatic accept(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [N-1:0] pat;
        logic [W:0]   held;

        // Reset has priority over start and x.
        reset = 1'b0; start = 1'b1; x = 1'b1; x_en = 1'b1; out_ready = 1'b0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);

        // In IDLE, x and x_en have no effect.
        reset = 1'b1; start = 1'b0;
        repeat (2) tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_valid", 32'(out_valid), 32'd0);
        x = 1'b0; x_en = 1'b0;

        // Unipolar window with 5 ones; the result is held while out_ready=0.
        pat = 16'b0010_0100_1000_1010;
        run_window("uni", pat, 0, 1'b1, 1'b0);
        held = out_data;
        for (int c = 0; c < 10; c++) begin
            x_en  = c[0];
            x     = 1'b1;
            start = (c == 4);
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(expect_of(pat)));
        end
        x = 1'b0; x_en = 1'b0; start = 1'b0;
        accept("uni");
        check("post_accept_data", 32'(out_data), 32'(held));

        // The same pattern with 7 stall cycles completes exactly 7 cycles later.
        run_window("stall", pat, 7, 1'b1, 1'b0);
        accept("stall");

        // Back-to-back: accepting with start=1 enters ACCUM directly.
        run_window("b2b_a", 16'($urandom), 0, 1'b1, 1'b0);
        out_ready = 1'b1; start = 1'b1;
        tick();
        out_ready = 1'b0; start = 1'b0;
        check("b2b_drop", 32'(out_valid), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        run_window("b2b_b", 16'hFFFF, 0, 1'b0, 1'b0);
        accept("b2b_b");

        // Readout boundary patterns: all zeros, alternating 1/0, and 12 ones.
        run_window("zeros", 16'h0000, 0, 1'b1, 1'b0);
        accept("zeros");
        run_window("alt", 16'h5555, 0, 1'b1, 1'b0);
        accept("alt");
        run_window("twelve", 16'h0FFF, 2, 1'b1, 1'b0);
        accept("twelve");

        // Abort at bit 9 with reset, then restart; only the new window counts.
        start = 1'b1;
        tick();
        start = 1'b0;
        x_en = 1'b1; x = 1'b1;
        repeat (9) tick();
        x_en = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_data", 32'(out_data), 32'd0);
        run_window("abort_new", 16'b0000_0011_0000_0001, 0, 1'b1, 1'b0);
        accept("abort_new");

        // A start pulsed mid-window is ignored, and the result timing is unchanged.
        run_window("poke", 16'($urandom), 3, 1'b1, 1'b1);
        accept("poke");

        // Random windows with random stalls.
        for (int r = 0; r < 6; r++) begin
            run_window("rand", 16'($urandom), int'($urandom_range(0, 5)), 1'b1, 1'b0);
            accept("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
